// File: rtl/alu_sched_pkg.sv
// alu_scheduler shared definitions: opcodes, scheduler states and the
// select encodings of the logical unit and shifter.
package alu_sched_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_ROR = 4'd8,
        OP_MUL = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

    // Logical unit selects
    localparam logic [1:0] LU_AND = 2'd0;
    localparam logic [1:0] LU_OR  = 2'd1;
    localparam logic [1:0] LU_XOR = 2'd2;
    localparam logic [1:0] LU_NOT = 2'd3;

    // Shifter selects
    localparam logic [1:0] SH_SHL = 2'd0;
    localparam logic [1:0] SH_SHR = 2'd1;
    localparam logic [1:0] SH_ROR = 2'd2;

    // True for opcodes that the EXEC state completes in one cycle.
    function automatic logic op_is_single_cycle(input logic [3:0] op);
        return (op <= 4'd8);
    endfunction

endpackage

// File: rtl/alu_components.sv
// Combinational ALU building blocks shared by the scheduler datapath:
// full adder, ripple-carry adder, logical unit and one-bit shifter.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];
endmodule

module logical_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);
    import alu_sched_pkg::*;

    // Bitwise function selected by sel; NOT ignores b
    always_comb begin
        y = '0;
        case (sel)
            LU_AND:  y = a & b;
            LU_OR:   y = a | b;
            LU_XOR:  y = a ^ b;
            LU_NOT:  y = ~a;
            default: y = '0;
        endcase
    end
endmodule

module shifter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);
    import alu_sched_pkg::*;

    // Single-position logical shifts and right rotate
    always_comb begin
        y = a;
        case (sel)
            SH_SHL:  y = {a[WIDTH-2:0], 1'b0};
            SH_SHR:  y = {1'b0, a[WIDTH-1:1]};
            SH_ROR:  y = {a[0], a[WIDTH-1:1]};
            default: y = a;
        endcase
    end
endmodule

// File: rtl/alu_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: ptr names the requester with the
// highest priority, the search wraps around from there.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);
    // Scan from ptr upward; the first pending request wins
    always_comb begin
        int  cand;
        logic found;
        logic take;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        take  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            cand = (cand >= NREQ) ? (cand - NREQ) : cand;
            take = !found && req[cand];
            gnt[cand] = take;
            idx   = take ? IW'(cand) : idx;
            found = found | take;
        end
    end
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one ALU (ripple adder, logical unit, shifter)
// between NREQ requesters. Round-robin issue, single-cycle ops in EXEC,
// optional shift-add multiply enabled by the ALU_SCHED_MUL_EN macro.
// Results return on a valid/ready channel tagged with the requester id.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][3:0]       req_op,
    input  logic [NREQ-1:0][WIDTH-1:0] req_a,
    input  logic [NREQ-1:0][WIDTH-1:0] req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_cout,
    output logic                       rsp_err,
    output logic [$clog2(NREQ)-1:0]    rsp_id
);
    localparam int             IDW     = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    sched_state_t     state_r;
    sched_state_t     state_nxt_s;

    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   ptr_nxt_s;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDW-1:0]   id_r;

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             cout_r;
    logic             err_r;
    logic [IDW-1:0]   rsp_id_r;

    logic [NREQ-1:0]  gnt_s;
    logic [IDW-1:0]   win_idx_s;
    logic             accept_s;
    logic             win_is_mul_s;
    logic             mul_phase_s;
    logic             mul_last_s;
    logic [WIDTH-1:0] acc_s;

    logic [WIDTH-1:0] add_a_s;
    logic [WIDTH-1:0] add_b_s;
    logic             add_cin_s;
    logic [WIDTH-1:0] sum_s;
    logic             add_cout_s;
    logic [1:0]       lu_sel_s;
    logic [WIDTH-1:0] lu_y_s;
    logic [1:0]       sh_sel_s;
    logic [WIDTH-1:0] sh_y_s;

    logic [WIDTH-1:0] alu_data_s;
    logic             alu_cout_s;
    logic             alu_err_s;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_r),
        .gnt (gnt_s),
        .idx (win_idx_s)
    );

    ripple_carry_adder #(.WIDTH(WIDTH)) u_add (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (sum_s),
        .cout (add_cout_s)
    );

    logical_unit #(.WIDTH(WIDTH)) u_lu (
        .a   (a_r),
        .b   (b_r),
        .sel (lu_sel_s),
        .y   (lu_y_s)
    );

    shifter #(.WIDTH(WIDTH)) u_sh (
        .a   (a_r),
        .sel (sh_sel_s),
        .y   (sh_y_s)
    );

    // Priority after an accept starts at the requester after the winner
    assign ptr_nxt_s = (win_idx_s == LAST_ID) ? '0 : (win_idx_s + IDW'(1));

`ifdef ALU_SCHED_MUL_EN
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;

    assign win_is_mul_s = (req_op[win_idx_s] == OP_MUL);
    assign mul_phase_s  = (state_r == ST_MUL);
    assign mul_last_s   = mul_phase_s && (cnt_r == CW'(WIDTH - 1));
    assign acc_s        = acc_r;

    // Multiply accumulator and bit counter: one partial product per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (accept_s) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (mul_phase_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_r + CW'(1);
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end
`else
    assign win_is_mul_s = 1'b0;
    assign mul_phase_s  = 1'b0;
    assign mul_last_s   = 1'b0;
    assign acc_s        = '0;
`endif

    // Grant is offered only while idle and out of reset
    always_comb begin
        req_ready = '0;
        accept_s  = 1'b0;
        if ((state_r == ST_IDLE) && !rst) begin
            req_ready = gnt_s;
            accept_s  = |(req_valid & gnt_s);
        end else begin
            req_ready = '0;
            accept_s  = 1'b0;
        end
    end

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Scheduler next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = win_is_mul_s ? ST_MUL : ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_DONE;
`ifdef ALU_SCHED_MUL_EN
            ST_MUL: begin
                if (mul_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
`endif
            ST_DONE: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // ALU input steering: multiply adds the shifted multiplicand to acc
    always_comb begin
        add_a_s   = a_r;
        add_b_s   = b_r;
        add_cin_s = 1'b0;
        lu_sel_s  = LU_AND;
        sh_sel_s  = SH_SHL;
        if (mul_phase_s) begin
            add_a_s   = acc_s;
            add_b_s   = b_r[0] ? a_r : '0;
            add_cin_s = 1'b0;
            sh_sel_s  = SH_SHL;
        end else begin
            case (op_r)
                OP_SUB: begin
                    add_b_s   = ~b_r;
                    add_cin_s = 1'b1;
                end
                OP_OR:   lu_sel_s = LU_OR;
                OP_XOR:  lu_sel_s = LU_XOR;
                OP_NOT:  lu_sel_s = LU_NOT;
                OP_SHR:  sh_sel_s = SH_SHR;
                OP_ROR:  sh_sel_s = SH_ROR;
                default: add_cin_s = 1'b0;
            endcase
        end
    end

    // Single-cycle result select; anything unknown here is an error
    always_comb begin
        alu_data_s = '0;
        alu_cout_s = 1'b0;
        alu_err_s  = 1'b0;
        case (op_r)
            OP_ADD, OP_SUB: begin
                alu_data_s = sum_s;
                alu_cout_s = add_cout_s;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: alu_data_s = lu_y_s;
            OP_SHL, OP_SHR, OP_ROR:        alu_data_s = sh_y_s;
            default: begin
                alu_data_s = '0;
                alu_cout_s = 1'b0;
                alu_err_s  = !op_is_single_cycle(op_r);
            end
        endcase
    end

    // Latch the winner's request; multiply walks a left and b right
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
            op_r  <= 4'd0;
            a_r   <= '0;
            b_r   <= '0;
            id_r  <= '0;
        end else if (accept_s) begin
            ptr_r <= ptr_nxt_s;
            op_r  <= req_op[win_idx_s];
            a_r   <= req_a[win_idx_s];
            b_r   <= req_b[win_idx_s];
            id_r  <= win_idx_s;
        end else if (mul_phase_s) begin
            a_r   <= sh_y_s;
            b_r   <= {1'b0, b_r[WIDTH-1:1]};
        end else begin
            a_r   <= a_r;
            b_r   <= b_r;
        end
    end

    // Response registers: loaded on completion, held until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r  <= 1'b0;
            data_r   <= '0;
            cout_r   <= 1'b0;
            err_r    <= 1'b0;
            rsp_id_r <= '0;
        end else if (state_r == ST_EXEC) begin
            valid_r  <= 1'b1;
            data_r   <= alu_data_s;
            cout_r   <= alu_cout_s;
            err_r    <= alu_err_s;
            rsp_id_r <= id_r;
        end else if (mul_last_s) begin
            valid_r  <= 1'b1;
            data_r   <= sum_s;
            cout_r   <= 1'b0;
            err_r    <= 1'b0;
            rsp_id_r <= id_r;
        end else if ((state_r == ST_DONE) && rsp_ready) begin
            valid_r  <= 1'b0;
        end else begin
            valid_r  <= valid_r;
        end
    end

    assign rsp_valid = valid_r;
    assign rsp_data  = data_r;
    assign rsp_cout  = cout_r;
    assign rsp_err   = err_r;
    assign rsp_id    = rsp_id_r;

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler against a behavioural model
// (plain arithmetic results, round-robin winner from the last grant).
module tb_alu_scheduler;
    localparam int W  = 8;
    localparam int N  = 2;
    localparam int IW = $clog2(N);
`ifdef ALU_SCHED_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0][3:0]      req_op;
    logic [N-1:0][W-1:0]    req_a;
    logic [N-1:0][W-1:0]    req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [W-1:0]           rsp_data;
    logic                   rsp_cout;
    logic                   rsp_err;
    logic [IW-1:0]          rsp_id;

    int checks   = 0;
    int failures = 0;
    int last_gnt = N - 1;

    alu_scheduler #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    // Reference ALU from the opcode definitions
    function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] d, output logic c, output logic e);
        int unsigned ai = a;
        int unsigned bi = b;
        int unsigned full;
        d = '0; c = 1'b0; e = 1'b0;
        case (op)
            4'd0: begin full = ai + bi; d = W'(full); c = (full >= (2**W)); end
            4'd1: begin d = W'(ai - bi); c = (ai >= bi); end
            4'd2: d = a & b;
            4'd3: d = a | b;
            4'd4: d = a ^ b;
            4'd5: d = ~a;
            4'd6: d = W'(ai * 2);
            4'd7: d = W'(ai / 2);
            4'd8: d = W'(ai / 2 + (ai % 2) * (2**(W-1)));
            4'd9: begin
                if (MUL_ON) d = W'(ai * bi);
                else        e = 1'b1;
            end
            default: e = 1'b1;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op);
        return (MUL_ON && op == 4'd9) ? (W + 1) : 2;
    endfunction

    function automatic int ref_winner(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_gnt = N - 1;
    endtask

    // Offer mask, wait for the grant and then the response; lat is the
    // edge (counted from the accept edge T) at which rsp_valid is first seen
    task automatic do_txn(input logic [N-1:0] mask, output int gid, output int lat, output bit to);
        int n = 0;
        int ones = 0;
        gid = -1; lat = 0; to = 1'b0;
        req_valid = mask;
        #1;
        while (req_ready == '0 && n < 30) begin
            @(negedge clk); #1; n++;
        end
        if (req_ready == '0) begin
            to = 1'b1; req_valid = '0;
            return;
        end
        for (int i = 0; i < N; i++) if (req_ready[i]) begin gid = i; ones++; end
        if (ones != 1) gid = -1;
        @(posedge clk); #1;
        req_valid = '0;
        while (lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (rsp_valid) break;
        end
        lat = lat + 1;
        if (!rsp_valid) to = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b1; req_valid = '1;
        for (int i = 0; i < N; i++) begin req_op[i] = 4'd0; req_a[i] = W'($urandom); req_b[i] = W'($urandom); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== '0) begin failures++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        checks++;
        if ({rsp_valid, rsp_data, rsp_cout, rsp_err, rsp_id} !== '0) begin
            failures++;
            $display("FAIL reset_rsp: got valid=%b data=%h cout=%b err=%b id=%0d expected all 0",
                     rsp_valid, rsp_data, rsp_cout, rsp_err, rsp_id);
        end
        rst = 1'b0; req_valid = '0; last_gnt = N - 1;
    endtask

    task automatic test_directed();
        logic [3:0]   t_op [6] = '{4'd0, 4'd1, 4'd1, 4'hF, 4'd9, 4'd9};
        logic [W-1:0] t_a  [6] = '{8'hFF, 8'h05, 8'h07, 8'h12, 8'd13, 8'd20};
        logic [W-1:0] t_b  [6] = '{8'h01, 8'h07, 8'h05, 8'h34, 8'd11, 8'd20};
        logic [W-1:0] e_d  [6];
        logic         e_c  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic         e_e  [6];
        int           e_l  [6];
        int gid, lat;
        bit to;
        e_d = '{8'h00, 8'hFE, 8'h02, 8'h00, (MUL_ON ? 8'h8F : 8'h00), (MUL_ON ? 8'h90 : 8'h00)};
        e_e = '{1'b0, 1'b0, 1'b0, 1'b1, !MUL_ON, !MUL_ON};
        e_l = '{2, 2, 2, 2, (MUL_ON ? W + 1 : 2), (MUL_ON ? W + 1 : 2)};
        for (int t = 0; t < 6; t++) begin
            req_op[0] = t_op[t]; req_a[0] = t_a[t]; req_b[0] = t_b[t];
            do_txn(2'b01, gid, lat, to);
            last_gnt = 0;
            checks++;
            if (to || gid !== 0 || lat !== e_l[t] || rsp_data !== e_d[t] || rsp_cout !== e_c[t]
                || rsp_err !== e_e[t] || rsp_id !== 0) begin
                failures++;
                $display("FAIL directed[%0d] op=%h: got to=%b gnt=%0d lat=T+%0d data=%h cout=%b err=%b id=%0d expected gnt=0 lat=T+%0d data=%h cout=%b err=%b id=0",
                         t, t_op[t], to, gid, lat, rsp_data, rsp_cout, rsp_err, rsp_id,
                         e_l[t], e_d[t], e_c[t], e_e[t]);
            end
        end
    endtask

    task automatic test_round_robin();
        int g_cyc [4];
        int ng = 0;
        int exp_w;
        int got_w;
        apply_reset();
        for (int i = 0; i < N; i++) begin req_op[i] = 4'd0; req_a[i] = W'($urandom); req_b[i] = W'($urandom); end
        req_valid = '1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            #1;
            if (req_ready != '0) begin
                got_w = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) got_w = i;
                exp_w = ref_winner(req_valid, last_gnt);
                checks++;
                if (got_w !== exp_w) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", ng, got_w, exp_w);
                end
                if (ng < 4) g_cyc[ng] = cyc;
                last_gnt = exp_w;
                ng++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        checks++;
        if (ng < 4) begin
            failures++;
            $display("FAIL rr_count: got %0d grants expected at least 4", ng);
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (g_cyc[k] - g_cyc[k-1] !== 3) begin
                    failures++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", k, g_cyc[k] - g_cyc[k-1]);
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ed; logic ec, ee;
        logic [W-1:0] d0; logic c0, e0; logic [IW-1:0] id0;
        int gid, lat;
        bit to;
        rsp_ready = 1'b0;
        req_op[1] = 4'd4; req_a[1] = W'($urandom); req_b[1] = W'($urandom);
        ref_alu(req_op[1], req_a[1], req_b[1], ed, ec, ee);
        do_txn(2'b10, gid, lat, to);
        last_gnt = 1;
        d0 = rsp_data; c0 = rsp_cout; e0 = rsp_err; id0 = rsp_id;
        checks++;
        if (to || gid !== 1 || d0 !== ed || c0 !== ec || e0 !== ee || id0 !== 1) begin
            failures++;
            $display("FAIL bp_result: got to=%b gnt=%0d data=%h id=%0d expected gnt=1 data=%h id=1", to, gid, d0, id0, ed);
        end
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_cout !== c0 || rsp_err !== e0
                || rsp_id !== id0 || req_ready !== '0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h id=%0d ready=%b expected valid=1 data=%h id=%0d ready=0",
                         c, rsp_valid, rsp_data, rsp_id, req_ready, d0, id0);
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got valid=%b expected 0", rsp_valid); end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] ed; logic ec, ee;
        int n = 0;
        int gid, lat;
        bit to;
        bit seen = 1'b0;
        rsp_ready = 1'b0;
        req_op[0] = 4'd9; req_a[0] = W'($urandom); req_b[0] = W'($urandom);
        req_valid = 2'b01;
        #1;
        while (!req_ready[0] && n < 30) begin @(negedge clk); #1; n++; end
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_mid_grant: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req_valid = '1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || {rsp_valid, rsp_data, rsp_cout, rsp_err, rsp_id} !== '0) begin
            failures++;
            $display("FAIL rst_mid_values: got ready=%b valid=%b data=%h cout=%b err=%b id=%0d expected all 0",
                     req_ready, rsp_valid, rsp_data, rsp_cout, rsp_err, rsp_id);
        end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1; last_gnt = N - 1;
        for (int c = 0; c < 15; c++) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_noresp: got a response expected none"); end
        req_op[1] = 4'd0; req_a[1] = W'($urandom); req_b[1] = W'($urandom);
        ref_alu(req_op[1], req_a[1], req_b[1], ed, ec, ee);
        do_txn(2'b10, gid, lat, to);
        last_gnt = 1;
        checks++;
        if (to || gid !== 1 || lat !== 2 || rsp_data !== ed || rsp_cout !== ec || rsp_err !== ee || rsp_id !== 1) begin
            failures++;
            $display("FAIL rst_mid_after: got to=%b gnt=%0d lat=%0d data=%h cout=%b id=%0d expected gnt=1 lat=2 data=%h cout=%b id=1",
                     to, gid, lat, rsp_data, rsp_cout, rsp_id, ed, ec);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        logic [W-1:0] ed; logic ec, ee;
        int exp_w, exp_l;
        int gid, lat;
        bit to;
        for (int it = 0; it < 60; it++) begin
            mask = N'($urandom_range(1, (2**N) - 1));
            for (int i = 0; i < N; i++) begin
                req_op[i] = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
                req_a[i]  = W'($urandom);
                req_b[i]  = W'($urandom);
            end
            exp_w = ref_winner(mask, last_gnt);
            ref_alu(req_op[exp_w], req_a[exp_w], req_b[exp_w], ed, ec, ee);
            exp_l = ref_latency(req_op[exp_w]);
            do_txn(mask, gid, lat, to);
            last_gnt = exp_w;
            checks++;
            if (to || gid !== exp_w || lat !== exp_l || rsp_data !== ed || rsp_cout !== ec
                || rsp_err !== ee || rsp_id !== IW'(exp_w)) begin
                failures++;
                $display("FAIL random[%0d] mask=%b op=%h: got to=%b gnt=%0d lat=%0d data=%h cout=%b err=%b id=%0d expected gnt=%0d lat=%0d data=%h cout=%b err=%b",
                         it, mask, req_op[exp_w], to, gid, lat, rsp_data, rsp_cout, rsp_err, rsp_id,
                         exp_w, exp_l, ed, ec, ee);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1; rst = 1'b1;
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares a single WIDTH-bit ALU between NREQ requesters. The ALU comprises a ripple-carry adder, a logical unit and a shifter. The block round-robin arbitrates requests, latches the winner's operands, and sequences single-cycle ops or an optional multi-cycle shift-add multiply. It returns the result on a valid/ready response channel tagged with the requester id. It sits between the register-file/issue logic and the combinational ALU components.

## Interface
- WIDTH, 8, operand/result width (≥2)
- NREQ, 2, number of requesters (≥2)
- clk  in  1  rising-edge clock, only clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot grant; accept = req_valid[i] & req_ready[i]
- req_op  in  NREQ×4  per-requester opcode (alu_op_t)
- req_a, req_b  in  NREQ×WIDTH  per-requester operands
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  WIDTH  result
- rsp_cout  out  1  carry out (ADD), no-borrow (SUB), else 0
- rsp_err  out  1  illegal/disabled opcode
- rsp_id  out  $clog2(NREQ)  index of requester served

## Operation
- Opcodes:
  - 0 ADD: a+b, cin 0
  - 1 SUB: a+~b, cin 1
  - 2 AND, 3 OR, 4 XOR
  - 5 NOT: ~a
  - 6 SHL: a<<1
  - 7 SHR: a>>1
  - 8 ROR: rotate a right 1
  - 9 MUL: low WIDTH bits of a*b
  - 10–15 illegal
- FSM states:
  - IDLE: req_ready asserted combinationally for the arbiter winner only, never in other states. On accept: latch op/a/b/id, update RR pointer to winner; go to MUL if op==MUL (and enabled), else EXEC.
  - EXEC: one cycle. Drive the latched operands through the ALU, register data/cout/err; go to DONE.
  - MUL: WIDTH cycles, one adder pass per cycle. acc += (b[k] ? a<<k : 0), k = 0..WIDTH-1, mod 2^WIDTH. After the last bit, go to DONE; cout=0.
  - DONE: rsp_valid=1. rsp_* hold stable until rsp_ready. On handshake go to IDLE; no accept in the same cycle.
- Arbiter: round-robin. Priority starts at the requester after the last granted one. The pointer changes only on accept. Requesters not granted keep their requests pending; none are dropped.
- Illegal op: passes through EXEC, rsp_data=0, rsp_cout=0, rsp_err=1.
- All arithmetic is modulo 2^WIDTH; carries beyond bit WIDTH are discarded except rsp_cout.

## Timing
- Reset values:
  - State: IDLE; RR pointer: requester 0 highest priority
  - req_ready=0 during the reset cycle
  - rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_err=0, rsp_id=0
- Latency, accept at edge T:
  - Single-cycle op: rsp_valid high from T+2
  - MUL: rsp_valid high from T+WIDTH+1
- Minimum issue interval: 3 cycles for single-cycle ops, WIDTH+2 cycles for MUL.
- A response accepted at edge T allows a new accept at edge T+1.
- rst asserted in any state, including mid-MUL or DONE: next cycle IDLE with all reset values. In-flight op discarded, no response.
- req_valid deasserting without accept is legal; no state change.

## Configuration
- ALU_SCHED_MUL_EN defined: MUL state and shift-add sequencing compiled in; opcode 9 is legal.
- ALU_SCHED_MUL_EN undefined: no MUL state or accumulator; opcode 9 treated as illegal (rsp_err=1, data 0, latency 2).

## Structure
- Package alu_sched_pkg: alu_op_t enum (4-bit), sched_state_t enum, OP_* constants.
- Sub-module rr_arbiter #(NREQ): inputs req, ptr; outputs one-hot gnt and encoded index. Combinational, instantiated once.
- ALU datapath reuses full_adder/ripple_carry_adder, logical_unit and shifter instances; no new arithmetic modules.

## Test plan
- req0 ADD 8'hFF+8'h01 → rsp_data 8'h00, rsp_cout 1, rsp_id 0, rsp_valid at T+2.
- req0 SUB 8'h05−8'h07 → rsp_data 8'hFE, rsp_cout 0. Same with 8'h07−8'h05 → 8'h02, cout 1.
- Both requesters valid continuously after reset, rsp_ready=1 → grant order 0,1,0,1; each issue 3 cycles apart.
- MUL 13×11 → 8'h8F at T+9. MUL 20×20 → 8'h90, cout 0. Without the macro, MUL → rsp_err 1, data 0.
- rsp_ready low 5 cycles in DONE → rsp_* stable, req_ready all 0. Opcode 4'hF → rsp_err 1, rsp_data 0.
- rst pulsed on MUL cycle 4 → next cycle all outputs at reset values; no response for that op; next request served normally.
